// File: rtl/cube_pkg.sv
// cube_pkg: face/turn encodings, FSM states and turn inversion for the cube move sequencer.
package cube_pkg;
  localparam int MOVE_W = 5;
  typedef enum logic [2:0] {FACE_U, FACE_D, FACE_F, FACE_B, FACE_L, FACE_R} face_e;
  typedef enum logic [1:0] {TURN_MARK, TURN_CW, TURN_CCW, TURN_DBL} turn_e;
  localparam logic [1:0] MARKER_TURN = TURN_MARK;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FINISH} state_e;
  function automatic logic [1:0] inv_turn(input logic [1:0] t);
    return t == TURN_CW ? TURN_CCW : t == TURN_CCW ? TURN_CW : t;
  endfunction
endpackage

// File: rtl/cube_script_ram.sv
// cube_script_ram: DEPTH x MOVE_W script store, synchronous write, asynchronous read, no reset.
module cube_script_ram
  import cube_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [MOVE_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [MOVE_W-1:0] o_rdata
);
  logic [MOVE_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cube_move_sequencer.sv
// cube_move_sequencer: replays a stored face-turn script over valid/ready, tracking phase and move count.
// Define CUBE_SEQ_REVERSE_EN to add the `reverse` input (backward playback with inverted turns).
module cube_move_sequencer
  import cube_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int NPHASE = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = NPHASE > 1 ? $clog2(NPHASE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [MOVE_W-1:0] load_data,
  input  logic [AW:0]       script_len,
  input  logic              start,
  input  logic              abort,
`ifdef CUBE_SEQ_REVERSE_EN
  input  logic              reverse,
`endif
  output logic              move_valid,
  input  logic              move_ready,
  output logic [MOVE_W-1:0] move,
  output logic [PW-1:0]     phase,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       move_count
);
  localparam logic [PW-1:0] PMAX = PW'(NPHASE - 1);
  state_e            r_state;
  logic [AW-1:0]     r_ptr;
  logic [AW:0]       r_rem;
  logic [PW-1:0]     r_phase;
  logic [AW:0]       r_count;
  logic [MOVE_W-1:0] r_move;
  logic              r_valid;
  logic              r_rev;
  logic              w_rev_in;
  logic [MOVE_W-1:0] w_entry;
  logic [AW-1:0]     w_ptr_nxt;
  logic [PW-1:0]     w_phase_nxt;
  logic              w_last;
`ifdef CUBE_SEQ_REVERSE_EN
  assign w_rev_in = reverse;
`else
  assign w_rev_in = 1'b0;
`endif
  cube_script_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .i_we   (load_en && r_state == IDLE),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(r_ptr),
    .o_rdata(w_entry)
  );
  assign w_ptr_nxt   = r_rev ? r_ptr - AW'(1) : r_ptr + AW'(1);
  assign w_phase_nxt = r_rev ? (r_phase == '0 ? r_phase : r_phase - PW'(1))
                             : (r_phase == PMAX ? r_phase : r_phase + PW'(1));
  // r_rem counts entries still to consume, so "last" is direction-independent
  assign w_last = r_rem == (AW+1)'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_phase <= '0;
      r_count <= '0;
      r_move  <= '0;
      r_valid <= 1'b0;
      r_rev   <= 1'b0;
    end else if (abort && r_state != IDLE) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: if (start) begin
          r_rev   <= w_rev_in;
          r_ptr   <= w_rev_in ? AW'(script_len - (AW+1)'(1)) : '0;
          r_rem   <= script_len;
          r_phase <= w_rev_in ? PMAX : '0;
          r_count <= '0;
          r_state <= script_len == '0 ? FINISH : FETCH;
        end
        FETCH: if (w_entry[1:0] == MARKER_TURN) begin
          r_phase <= w_phase_nxt;
          r_ptr   <= w_ptr_nxt;
          r_rem   <= r_rem - (AW+1)'(1);
          r_state <= w_last ? FINISH : FETCH;
        end else begin
          r_move  <= r_rev ? {w_entry[4:2], inv_turn(w_entry[1:0])} : w_entry;
          r_valid <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: if (move_ready) begin
          r_valid <= 1'b0;
          r_count <= r_count + (AW+1)'(1);
          r_ptr   <= w_ptr_nxt;
          r_rem   <= r_rem - (AW+1)'(1);
          r_state <= w_last ? FINISH : FETCH;
        end
        FINISH: r_state <= IDLE;
      endcase
  assign move_valid = r_valid;
  assign move       = r_move;
  assign phase      = r_phase;
  assign busy       = r_state != IDLE;
  assign done       = r_state == FINISH;
  assign move_count = r_count;
endmodule
